// File: rtl/sram_1r1w_masked_init.sv
// sram_1r1w_masked_init
// Single-clock 1R1W SRAM model with per-lane write masking, write-first
// collision bypass, a 1- or 2-cycle read pipeline with a valid strobe, and a
// post-reset sequencer that clears every word before traffic is accepted.
//
// Ports:
//   clock     rising-edge clock for all state and memory
//   reset     asynchronous, active-high
//   ready     high when W0/R0 requests are accepted
//   W0_en     write request
//   W0_addr   write address
//   W0_data   write data
//   W0_mask   lane enables (lane i = bits [(i+1)*LW-1 : i*LW])
//   R0_en     read request
//   R0_addr   read address
//   R0_data   read data, holds the last delivered result
//   R0_valid  one-cycle strobe marking a new result on R0_data
module sram_1r1w_masked_init #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 36,
  parameter int MASK_WIDTH     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  W0_en,
  input  logic [ADDR_WIDTH-1:0] W0_addr,
  input  logic [DATA_WIDTH-1:0] W0_data,
  input  logic [MASK_WIDTH-1:0] W0_mask,
  input  logic                  R0_en,
  input  logic [ADDR_WIDTH-1:0] R0_addr,
  output logic [DATA_WIDTH-1:0] R0_data,
  output logic                  R0_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / MASK_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("sram_1r1w_masked_init: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask
      $error("sram_1r1w_masked_init: DATA_WIDTH must be divisible by MASK_WIDTH");
    end
  endgenerate

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  ready_reg;
  logic                  clear_we;

  // Clear sequencer: one word per cycle, then RUN forever.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    clear_we   = 1'b0;
    case (state_reg)
      CLEAR: begin
        clear_we   = 1'b1;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_WORD) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      count_reg <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      // Registered from the next state so ready rises on the same edge the
      // FSM enters RUN (the edge that writes the last word).
      ready_reg <= (state_next == RUN);
    end
  end

  assign ready = ready_reg;

  // Requests are only honoured while ready; ready is low throughout CLEAR,
  // so sequencer writes and user writes never compete for the write port.
  logic wr_acc, rd_acc;
  assign wr_acc = ready_reg & W0_en;
  assign rd_acc = ready_reg & R0_en;

  // Lane mask expanded to bit granularity.
  logic [DATA_WIDTH-1:0] mask_bits;
  generate
    for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_mask
      assign mask_bits[gi*LW +: LW] = {LW{W0_mask[gi]}};
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] lane_we;

  always_comb begin
    mem_waddr = W0_addr;
    mem_wdata = W0_data;
    lane_we   = wr_acc ? W0_mask : '0;
    if (clear_we) begin
      mem_waddr = count_reg[ADDR_WIDTH-1:0];
      mem_wdata = CLEAR_VALUE;
      lane_we   = '1;
    end
  end

  // Memory array and its registered read port. Contents are never reset;
  // only the clear sequence initialises them.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [DATA_WIDTH-1:0] byp_bits_reg;

  always_ff @(posedge clock) begin
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (lane_we[i]) begin
        mem[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
      end
    end
    if (rd_acc) begin
      // Read returns pre-write contents; the colliding write lanes are
      // captured alongside and merged in the next stage (write-first).
      rd_word_reg  <= mem[R0_addr];
      byp_data_reg <= W0_data;
      byp_bits_reg <= (wr_acc && (W0_addr == R0_addr)) ? mask_bits : '0;
    end
  end

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data;

  assign s1_data = (rd_word_reg & ~byp_bits_reg) | (byp_data_reg & byp_bits_reg);

  logic                  out_valid_src;
  logic [DATA_WIDTH-1:0] out_data_src;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_reg;
      logic [DATA_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data;
          end
        end
      end

      assign out_valid_src = s2_valid_reg;
      assign out_data_src  = s2_data_reg;
    end else begin : g_lat1
      assign out_valid_src = s1_valid_reg;
      assign out_data_src  = s1_data;
    end
  endgenerate

  // Reset flushes the valid pipeline so no in-flight read can strobe later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      R0_valid     <= 1'b0;
      R0_data      <= '0;
    end else begin
      s1_valid_reg <= rd_acc;
      R0_valid     <= out_valid_src;
      if (out_valid_src) begin
        R0_data <= out_data_src;
      end
    end
  end

endmodule

// File: doc/sram_1r1w_masked_init.md
# sram_1r1w_masked_init

Parametrised single-clock 1R1W SRAM behavioural model. It adds per-lane write masking, write-first read/write collision bypass, and a 1- or 2-cycle read pipeline with a valid strobe. Read data holds its last value instead of going X. After reset, an internal sequencer clears every word before the block accepts traffic. It replaces the fixed 256x36 dual-clock macro models in lane-local buffers where deterministic post-reset contents and partial-word updates are required.

## Interface
Parameters:
- ADDR_WIDTH, 8: address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 36: word width.
- MASK_WIDTH, 4: write lanes. DATA_WIDTH must be divisible by MASK_WIDTH; lane width = DATA_WIDTH/MASK_WIDTH (9 by default). Lane i = bits [(i+1)*LW-1 : i*LW].
- READ_LATENCY, 1: legal values are 1 and 2. Any other value is an elaboration error.
- CLEAR_ON_RESET, 1: 1 runs the post-reset clear; 0 makes the block ready one cycle after reset release.
- CLEAR_VALUE, 0: DATA_WIDTH-bit value written to every word during clear.

Ports (single clock domain; one clock; reset is asynchronous and active-high):
- clock  input  1  rising-edge clock for all state and memory.
- reset  input  1  asynchronous, active-high.
- ready  output  1  high when the block accepts W0/R0 requests.
- W0_en  input  1  write request.
- W0_addr  input  ADDR_WIDTH  write address.
- W0_data  input  DATA_WIDTH  write data.
- W0_mask  input  MASK_WIDTH  lane enables; a lane is written only when its bit is 1.
- R0_en  input  1  read request.
- R0_addr  input  ADDR_WIDTH  read address.
- R0_data  output  DATA_WIDTH  read data; holds last returned value.
- R0_valid  output  1  one-cycle strobe that R0_data carries a new read result.

## Operation
- State machine CLEAR, RUN:
  - Reset drives the FSM to CLEAR if CLEAR_ON_RESET=1, else to RUN. It also zeroes the clear counter.
  - CLEAR: each cycle writes CLEAR_VALUE to word[counter], then increments the counter. After word 2^ADDR_WIDTH-1 is written, the FSM goes to RUN. The counter is ADDR_WIDTH+1 bits so the terminal condition does not alias at wrap-around.
  - RUN: terminal state until the next reset.
- ready = (state == RUN), registered.
- Requests are accepted only when ready=1. While ready=0, W0_en and R0_en are ignored: no memory update and no R0_valid.
- Write: an accepted write updates only masked lanes at the clock edge. A mask of 0 is a legal no-op.
- Read: an accepted read samples memory at R0_addr in the accept cycle.
- Collision (W0_en & R0_en & equal addresses, same cycle) is write-first. Returned data is new W0_data in masked lanes and old contents in unmasked lanes.
- Write followed by a read of the same address in a later cycle returns the written data; no hazard exists.
- Simultaneous read and write to different addresses are independent.
- R0_data updates only when a result is delivered; otherwise it holds. It never outputs X.
- Reset mid-clear or mid-read:
  - The clear restarts from word 0.
  - In-flight reads are discarded: R0_valid is 0 and no late strobe appears.
  - Memory contents are not reset except by the clear sequence.

## Timing
- Reset values: ready=0, R0_valid=0, R0_data=0, state=CLEAR (or RUN when CLEAR_ON_RESET=0), counter=0.
- Clear duration: ready rises exactly 2^ADDR_WIDTH cycles after the first rising edge with reset low (256 by default). With CLEAR_ON_RESET=0, ready rises after 1 cycle.
- Read latency:
  - READ_LATENCY=1: a read accepted at edge N gives R0_valid=1 and R0_data after edge N+1 (one cycle).
  - READ_LATENCY=2: a read accepted at edge N gives R0_valid after edge N+2.
- Back-to-back reads every cycle give full throughput, one result per cycle, in request order.
- The collision bypass value is captured at the accept edge. A later write to the same address does not alter an in-flight result.

## Test plan
- Reset/clear: release reset and count cycles -> ready rises at cycle 256. Reads of addresses 0x00, 0x7F and 0xFF return 0x000000000. No R0_valid appears for requests issued while ready=0.
- Masked write: write 0xFFFFFFFFF mask 4'b1111 to addr 5, then write 0x000000000 mask 4'b0101 to addr 5, then read addr 5 -> 0xFF803FE00.
- Full collision: addr 0x10 holds 0x123456789; same cycle write 0xABCDEF012 mask 4'b1111 and read 0x10 -> R0_data=0xABCDEF012. A later read of 0x10 -> 0xABCDEF012.
- Partial collision: addr 0x10 holds 0x123456789; same cycle write 0xABCDEF012 mask 4'b0001 and read 0x10 -> 0x123456612.
- Hold/latency: for READ_LATENCY=1 and 2, read addr 3 holding 0x000000ABC, then R0_en=0 for 3 cycles:
  - R0_valid pulses once, exactly 1 or 2 cycles after accept.
  - R0_data stays 0x000000ABC throughout.
- Reset mid-operation:
  - Assert reset at clear cycle 100 -> ready=0 immediately; after release, ready needs a full 256 cycles.
  - Assert reset with a READ_LATENCY=2 read in flight -> no R0_valid pulse, and R0_data=0.
